// File: rtl/clock_pkg.sv
// Shared constants, display struct and binary-to-BCD helpers for the
// seconds/minutes/hours time-of-day counter.
package clock_pkg;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR24_MAX = 23;
    localparam int HOUR12_MAX = 12;

    localparam int ONES_W      = 4;
    localparam int SEC_TENS_W  = 3;
    localparam int MIN_TENS_W  = 3;
    localparam int HOUR_TENS_W = 2;

    typedef struct packed {
        logic                   pm;
        logic [HOUR_TENS_W-1:0] hour_tens;
        logic [ONES_W-1:0]      hour_ones;
        logic [MIN_TENS_W-1:0]  min_tens;
        logic [ONES_W-1:0]      min_ones;
        logic [SEC_TENS_W-1:0]  sec_tens;
        logic [ONES_W-1:0]      sec_ones;
    } time_bcd_t;

    // Returns {tens[2:0], ones[3:0]} for a binary value 0..63.
    function automatic logic [6:0] bin_to_bcd(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return {t[2:0], 4'(v - t * 6'd10)};
    endfunction

    // Returns {tens[1:0], ones[3:0]} for an hour value 0..23.
    function automatic logic [5:0] hour_to_bcd(input logic [4:0] h);
        logic [1:0] t;
        if (h >= 5'd20)      t = 2'd2;
        else if (h >= 5'd10) t = 2'd1;
        else                 t = 2'd0;
        return {t, 4'(h - 5'(t) * 5'd10)};
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control and BCD display bundle of the time-of-day counter.
interface time_counter_if;
    import clock_pkg::*;

    logic                   enb;
    logic                   load;
    logic [4:0]             load_hour;
    logic [5:0]             load_min;
    logic [5:0]             load_sec;
    logic                   inc_min;
    logic                   inc_hour;
    logic [ONES_W-1:0]      sec_ones;
    logic [SEC_TENS_W-1:0]  sec_tens;
    logic [ONES_W-1:0]      min_ones;
    logic [MIN_TENS_W-1:0]  min_tens;
    logic [ONES_W-1:0]      hour_ones;
    logic [HOUR_TENS_W-1:0] hour_tens;
    logic                   pm;
    logic                   min_carry;
    logic                   hour_carry;
    logic                   day_pulse;
    logic                   load_err;

    modport master (
        output enb, load, load_hour, load_min, load_sec, inc_min, inc_hour,
        input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
               pm, min_carry, hour_carry, day_pulse, load_err
    );

    modport slave (
        input  enb, load, load_hour, load_min, load_sec, inc_min, inc_hour,
        output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
               pm, min_carry, hour_carry, day_pulse, load_err
    );
endinterface

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with binary load, clear and a registered wrap pulse.
module bcd_mod60
    import clock_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  ld,
    input  logic                  wrap_en,
    input  logic [5:0]            ld_val,
    output logic [ONES_W-1:0]     ones,
    output logic [SEC_TENS_W-1:0] tens,
    output logic                  at_max,
    output logic                  wrap
);
    logic [ONES_W-1:0]     ones_reg, ones_next;
    logic [SEC_TENS_W-1:0] tens_reg, tens_next;
    logic                  wrap_reg, wrap_next;

    assign at_max = (ones_reg == 4'd9) && (tens_reg == 3'(SEC_MAX / 10));

    // wrap_en lets the parent suppress the pulse for manual adjustments.
    always_comb begin
        ones_next = ones_reg;
        tens_next = tens_reg;
        wrap_next = 1'b0;
        if (ld) begin
            {tens_next, ones_next} = bin_to_bcd(ld_val);
        end else if (clr) begin
            ones_next = '0;
            tens_next = '0;
        end else if (inc) begin
            if (ones_reg == 4'd9) begin
                ones_next = '0;
                if (at_max) begin
                    tens_next = '0;
                    wrap_next = wrap_en;
                end else begin
                    tens_next = tens_reg + 3'd1;
                end
            end else begin
                ones_next = ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_reg <= '0;
            tens_reg <= '0;
            wrap_reg <= 1'b0;
        end else begin
            ones_reg <= ones_next;
            tens_reg <= tens_next;
            wrap_reg <= wrap_next;
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;
    assign wrap = wrap_reg;
endmodule

// File: rtl/time_counter.sv
// Digital clock time keeper: seconds/minutes/hours as BCD, with load,
// manual adjust and 24 h or 12 h (with pm flag) hour handling.
module time_counter
    import clock_pkg::*;
#(
    parameter int TWELVE_HOUR = 0
) (
    input  logic           clk,
    input  logic           rst,
    time_counter_if.slave  bus
);
    localparam logic [4:0] HOUR_RST = (TWELVE_HOUR != 0) ? 5'(HOUR12_MAX) : 5'd0;

    logic load_ok, do_load, adj, tick, hour_roll, hour_step;
    logic sec_at_max, min_at_max;

    logic [4:0] hour_reg, hour_next;
    logic [5:0] hour_bcd_reg;
    logic       pm_reg, pm_next;
    logic       day_reg, day_next;
    logic       err_reg, err_next;

    // Event priority: load, then manual adjust, then the 1 Hz tick.
    assign load_ok   = (bus.load_hour <= 5'(HOUR24_MAX)) &&
                       (bus.load_min  <= 6'(MIN_MAX))    &&
                       (bus.load_sec  <= 6'(SEC_MAX));
    assign do_load   = bus.load && load_ok;
    assign adj       = !bus.load && (bus.inc_min || bus.inc_hour);
    assign tick      = !bus.load && !bus.inc_min && !bus.inc_hour && bus.enb;
    assign hour_roll = tick && sec_at_max && min_at_max;
    assign hour_step = (adj && bus.inc_hour) || hour_roll;

    bcd_mod60 u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc     (tick),
        .clr     (adj),
        .ld      (do_load),
        .wrap_en (1'b1),
        .ld_val  (bus.load_sec),
        .ones    (bus.sec_ones),
        .tens    (bus.sec_tens),
        .at_max  (sec_at_max),
        .wrap    (bus.min_carry)
    );

    bcd_mod60 u_min (
        .clk     (clk),
        .rst     (rst),
        .inc     ((adj && bus.inc_min) || (tick && sec_at_max)),
        .clr     (1'b0),
        .ld      (do_load),
        .wrap_en (tick),
        .ld_val  (bus.load_min),
        .ones    (bus.min_ones),
        .tens    (bus.min_tens),
        .at_max  (min_at_max),
        .wrap    (bus.hour_carry)
    );

    always_comb begin
        hour_next = hour_reg;
        pm_next   = pm_reg;
        day_next  = 1'b0;
        err_next  = bus.load && !load_ok;
        if (do_load) begin
            if (TWELVE_HOUR != 0) begin
                pm_next = (bus.load_hour >= 5'd12);
                if (bus.load_hour == 5'd0)      hour_next = 5'd12;
                else if (bus.load_hour > 5'd12) hour_next = bus.load_hour - 5'd12;
                else                            hour_next = bus.load_hour;
            end else begin
                hour_next = bus.load_hour;
                pm_next   = 1'b0;
            end
        end else if (hour_step) begin
            if (TWELVE_HOUR != 0) begin
                // 11 -> 12 flips AM/PM; only the PM->AM flip by the tick is midnight.
                if (hour_reg == 5'd11) begin
                    hour_next = 5'd12;
                    pm_next   = !pm_reg;
                    day_next  = hour_roll && pm_reg;
                end else if (hour_reg == 5'd12) begin
                    hour_next = 5'd1;
                end else begin
                    hour_next = hour_reg + 5'd1;
                end
            end else begin
                if (hour_reg == 5'(HOUR24_MAX)) begin
                    hour_next = 5'd0;
                    day_next  = hour_roll;
                end else begin
                    hour_next = hour_reg + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_reg     <= HOUR_RST;
            hour_bcd_reg <= hour_to_bcd(HOUR_RST);
            pm_reg       <= 1'b0;
            day_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            hour_reg     <= hour_next;
            hour_bcd_reg <= hour_to_bcd(hour_next);
            pm_reg       <= pm_next;
            day_reg      <= day_next;
            err_reg      <= err_next;
        end
    end

    assign bus.hour_tens = hour_bcd_reg[5:4];
    assign bus.hour_ones = hour_bcd_reg[3:0];
    assign bus.pm        = pm_reg;
    assign bus.day_pulse = day_reg;
    assign bus.load_err  = err_reg;
endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: one 24 h and one 12 h instance,
// expected values queued on a scoreboard and compared one cycle later.
module tb_time_counter;
    import clock_pkg::*;

    typedef struct packed {
        time_bcd_t t;
        logic      mc;
        logic      hc;
        logic      dp;
        logic      le;
    } obs_t;

    typedef struct {
        obs_t  v;
        string name;
    } exp_t;

    typedef struct {
        bit    ld;
        int    lh, lm, ls;
        bit    im, ih, en;
        obs_t  v;
        string name;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    time_counter_if if24 ();
    time_counter_if if12 ();

    time_counter #(.TWELVE_HOUR(0)) dut24 (.clk(clk), .rst(rst), .bus(if24));
    time_counter #(.TWELVE_HOUR(1)) dut12 (.clk(clk), .rst(rst), .bus(if12));

    always #5 clk = ~clk;

    function automatic obs_t mk(int hh, int mm, int ss, bit pm, bit mc, bit hc, bit dp, bit le);
        obs_t o;
        o.t.pm        = pm;
        o.t.hour_tens = 2'(hh / 10);
        o.t.hour_ones = 4'(hh % 10);
        o.t.min_tens  = 3'(mm / 10);
        o.t.min_ones  = 4'(mm % 10);
        o.t.sec_tens  = 3'(ss / 10);
        o.t.sec_ones  = 4'(ss % 10);
        o.mc = mc; o.hc = hc; o.dp = dp; o.le = le;
        return o;
    endfunction

    function automatic step_t st(bit ld, int lh, int lm, int ls, bit im, bit ih, bit en,
                                 obs_t v, string name);
        step_t s;
        s.ld = ld; s.lh = lh; s.lm = lm; s.ls = ls;
        s.im = im; s.ih = ih; s.en = en; s.v = v; s.name = name;
        return s;
    endfunction

    function automatic obs_t sample(bit m12);
        obs_t o;
        if (m12) begin
            o.t = {if12.pm, if12.hour_tens, if12.hour_ones, if12.min_tens, if12.min_ones,
                   if12.sec_tens, if12.sec_ones};
            o.mc = if12.min_carry; o.hc = if12.hour_carry;
            o.dp = if12.day_pulse; o.le = if12.load_err;
        end else begin
            o.t = {if24.pm, if24.hour_tens, if24.hour_ones, if24.min_tens, if24.min_ones,
                   if24.sec_tens, if24.sec_ones};
            o.mc = if24.min_carry; o.hc = if24.hour_carry;
            o.dp = if24.day_pulse; o.le = if24.load_err;
        end
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("%0d%0d:%0d%0d:%0d%0d pm=%0b mc=%0b hc=%0b dp=%0b le=%0b",
                         o.t.hour_tens, o.t.hour_ones, o.t.min_tens, o.t.min_ones,
                         o.t.sec_tens, o.t.sec_ones, o.t.pm, o.mc, o.hc, o.dp, o.le);
    endfunction

    task automatic idle_inputs();
        if24.enb = 0; if24.load = 0; if24.load_hour = 0; if24.load_min = 0;
        if24.load_sec = 0; if24.inc_min = 0; if24.inc_hour = 0;
        if12.enb = 0; if12.load = 0; if12.load_hour = 0; if12.load_min = 0;
        if12.load_sec = 0; if12.inc_min = 0; if12.inc_hour = 0;
    endtask

    // Drives one cycle of stimulus on the chosen instance, then samples at edge+1.
    task automatic drive(bit m12, bit ld, int lh, int lm, int ls, bit im, bit ih, bit en);
        if (m12) begin
            if12.load = ld; if12.load_hour = 5'(lh); if12.load_min = 6'(lm);
            if12.load_sec = 6'(ls); if12.inc_min = im; if12.inc_hour = ih; if12.enb = en;
        end else begin
            if24.load = ld; if24.load_hour = 5'(lh); if24.load_min = 6'(lm);
            if24.load_sec = 6'(ls); if24.inc_min = im; if24.inc_hour = ih; if24.enb = en;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        idle_inputs();
        rst = 1'b1;
        sb.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0), "reset24"});
        sb.push_back('{mk(12, 0, 0, 0, 0, 0, 0, 0), "reset12"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            e = sb.pop_front();
            o = sample(m[0]);
            checks++;
            $display("txn %s: %s", e.name, fmt(o));
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: got %s required %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_seconds();
        exp_t e;
        obs_t o;
        int   mc_idle = 0;
        for (int i = 1; i <= 60; i++) begin
            sb.push_back('{mk(0, i / 60, i % 60, 0, i == 60, 0, 0, 0), $sformatf("tick%0d", i)});
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            e = sb.pop_front();
            o = sample(0);
            checks++;
            $display("txn %s: %s", e.name, fmt(o));
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: got %s required %s", e.name, fmt(o), fmt(e.v));
            end
            for (int k = 0; k < 9; k++) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0);
                if (if24.min_carry) mc_idle++;
            end
        end
        checks++;
        $display("txn min_carry_idle: %0d", mc_idle);
        if (mc_idle !== 0) begin
            errors++;
            $display("FAIL min_carry_idle: got %0d pulses required 0", mc_idle);
        end
    endtask

    task automatic run_steps(bit m12, step_t q[$]);
        exp_t e;
        obs_t o;
        foreach (q[i]) begin
            sb.push_back('{q[i].v, q[i].name});
            drive(m12, q[i].ld, q[i].lh, q[i].lm, q[i].ls, q[i].im, q[i].ih, q[i].en);
            e = sb.pop_front();
            o = sample(m12);
            checks++;
            $display("txn %s: %s", e.name, fmt(o));
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: got %s required %s", e.name, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_rollover24();
        step_t q[$];
        q.push_back(st(1, 23, 59, 59, 0, 0, 0, mk(23, 59, 59, 0, 0, 0, 0, 0), "load_235959"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 1, 1, 0), "midnight24"));
        run_steps(0, q);
    endtask

    task automatic test_12h();
        step_t q[$];
        q.push_back(st(1, 11, 59, 59, 0, 0, 0, mk(11, 59, 59, 0, 0, 0, 0, 0), "load12_1159am"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(12, 0, 0, 1, 1, 1, 0, 0), "noon12"));
        q.push_back(st(1, 23, 59, 59, 0, 0, 0, mk(11, 59, 59, 1, 0, 0, 0, 0), "load12_1159pm"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(12, 0, 0, 0, 1, 1, 1, 0), "midnight12"));
        q.push_back(st(1, 12, 59, 59, 0, 0, 0, mk(12, 59, 59, 1, 0, 0, 0, 0), "load12_1259pm"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 1, 1, 1, 0, 0), "one_pm"));
        q.push_back(st(1, 0, 30, 10, 0, 0, 0, mk(12, 30, 10, 0, 0, 0, 0, 0), "load12_0h"));
        q.push_back(st(0, 0, 0, 0, 0, 1, 0, mk(1, 30, 0, 0, 0, 0, 0, 0), "inc_hour12_12to1"));
        q.push_back(st(1, 13, 5, 0, 0, 0, 0, mk(1, 5, 0, 1, 0, 0, 0, 0), "load12_13h"));
        q.push_back(st(1, 11, 20, 30, 0, 0, 0, mk(11, 20, 30, 0, 0, 0, 0, 0), "load12_11am"));
        q.push_back(st(0, 0, 0, 0, 0, 1, 0, mk(12, 20, 0, 1, 0, 0, 0, 0), "inc_hour12_am_pm"));
        q.push_back(st(1, 23, 20, 30, 0, 0, 0, mk(11, 20, 30, 1, 0, 0, 0, 0), "load12_11pm"));
        q.push_back(st(0, 0, 0, 0, 0, 1, 0, mk(12, 20, 0, 0, 0, 0, 0, 0), "inc_hour12_no_day"));
        run_steps(1, q);
    endtask

    task automatic test_load_err();
        step_t q[$];
        q.push_back(st(1, 10, 59, 37, 0, 0, 0, mk(10, 59, 37, 0, 0, 0, 0, 0), "load_105937"));
        q.push_back(st(1, 10, 60, 0, 0, 0, 0, mk(10, 59, 37, 0, 0, 0, 0, 1), "err_min60"));
        q.push_back(st(1, 24, 0, 0, 0, 0, 0, mk(10, 59, 37, 0, 0, 0, 0, 1), "err_hour24"));
        q.push_back(st(1, 5, 10, 60, 0, 0, 1, mk(10, 59, 37, 0, 0, 0, 0, 1), "err_sec60_enb"));
        q.push_back(st(1, 8, 0, 0, 0, 0, 1, mk(8, 0, 0, 0, 0, 0, 0, 0), "load_enb_drop"));
        q.push_back(st(1, 10, 59, 37, 0, 0, 1, mk(10, 59, 37, 0, 0, 0, 0, 0), "load_enb_105937"));
        run_steps(0, q);
    endtask

    task automatic test_adjust();
        step_t q[$];
        q.push_back(st(0, 0, 0, 0, 1, 0, 1, mk(10, 0, 0, 0, 0, 0, 0, 0), "inc_min_wrap_enb"));
        q.push_back(st(0, 0, 0, 0, 1, 0, 0, mk(10, 1, 0, 0, 0, 0, 0, 0), "inc_min"));
        q.push_back(st(1, 23, 45, 12, 0, 0, 0, mk(23, 45, 12, 0, 0, 0, 0, 0), "load_234512"));
        q.push_back(st(0, 0, 0, 0, 0, 1, 0, mk(0, 45, 0, 0, 0, 0, 0, 0), "inc_hour_23"));
        q.push_back(st(0, 0, 0, 0, 1, 1, 0, mk(1, 46, 0, 0, 0, 0, 0, 0), "inc_both"));
        q.push_back(st(1, 22, 59, 30, 0, 0, 0, mk(22, 59, 30, 0, 0, 0, 0, 0), "load_225930"));
        q.push_back(st(0, 0, 0, 0, 1, 1, 1, mk(23, 0, 0, 0, 0, 0, 0, 0), "inc_both_wrap"));
        q.push_back(st(1, 10, 20, 30, 1, 1, 0, mk(10, 20, 30, 0, 0, 0, 0, 0), "load_over_inc"));
        run_steps(0, q);
    endtask

    task automatic test_back_to_back();
        step_t q[$];
        q.push_back(st(1, 9, 59, 58, 0, 0, 0, mk(9, 59, 58, 0, 0, 0, 0, 0), "load_095958"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(9, 59, 59, 0, 0, 0, 0, 0), "b2b_1"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(10, 0, 0, 0, 1, 1, 0, 0), "b2b_2"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(10, 0, 1, 0, 0, 0, 0, 0), "b2b_3"));
        q.push_back(st(1, 10, 0, 9, 0, 0, 0, mk(10, 0, 9, 0, 0, 0, 0, 0), "load_100009"));
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(10, 0, 10, 0, 0, 0, 0, 0), "sec_ones_carry"));
        run_steps(0, q);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        step_t q[$];
        q.push_back(st(1, 23, 59, 59, 0, 0, 0, mk(23, 59, 59, 0, 0, 0, 0, 0), "pre_rst24"));
        run_steps(0, q);
        q.delete();
        q.push_back(st(1, 23, 59, 59, 0, 0, 0, mk(11, 59, 59, 1, 0, 0, 0, 0), "pre_rst12"));
        run_steps(1, q);
        sb.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0), "rst_mid24"});
        sb.push_back('{mk(12, 0, 0, 0, 0, 0, 0, 0), "rst_mid12"});
        rst = 1'b1;
        if24.enb = 1; if24.load = 1; if24.load_hour = 5; if24.load_min = 5; if24.load_sec = 5;
        if24.inc_min = 1; if24.inc_hour = 1;
        if12.enb = 1; if12.load = 1; if12.load_hour = 5; if12.load_min = 5; if12.load_sec = 5;
        if12.inc_min = 1; if12.inc_hour = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        for (int m = 0; m < 2; m++) begin
            e = sb.pop_front();
            o = sample(m[0]);
            checks++;
            $display("txn %s: %s", e.name, fmt(o));
            if (o !== e.v) begin
                errors++;
                $display("FAIL %s: got %s required %s", e.name, fmt(o), fmt(e.v));
            end
        end
        q.delete();
        q.push_back(st(0, 0, 0, 0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0), "post_rst_tick"));
        run_steps(0, q);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_seconds();
        test_rollover24();
        test_12h();
        test_load_err();
        test_adjust();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
